// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU pipeline sequencer: state encoding, NOP
// instruction word and the default drain depth.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_DRAIN = 2'd3
    } pipe_state_t;

    localparam logic [12:0] NOP_INSTR        = 13'h0000;
    localparam int          DRAIN_CYCLES_DEF = 3;

    // True when a live destination write targets the given source register.
    function automatic logic addr_match(input logic       wr_en,
                                        input logic [2:0] wr_addr,
                                        input logic [2:0] rs_addr);
        return wr_en && (wr_addr == rs_addr);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Read-after-write hazard compare between the decode-stage sources and the
// destinations still held in the execute and writeback latches.
module hazard_detect
    import cpu_ctrl_pkg::*;
(
    input  logic       rs_a_used_i,
    input  logic [2:0] rs_a_addr_i,
    input  logic       rs_b_used_i,
    input  logic [2:0] rs_b_addr_i,
    input  logic       ex_wr_en_i,
    input  logic [2:0] ex_wr_addr_i,
    input  logic       wb_wr_en_i,
    input  logic [2:0] wb_wr_addr_i,
    output logic       stall_o
);

    logic match_a_s;
    logic match_b_s;

    // The register file writes on the clock edge, so a writeback-latch match
    // still needs a stall cycle before decode can read the new value.
    always_comb begin
        match_a_s = addr_match(ex_wr_en_i, ex_wr_addr_i, rs_a_addr_i) |
                    addr_match(wb_wr_en_i, wb_wr_addr_i, rs_a_addr_i);
        match_b_s = addr_match(ex_wr_en_i, ex_wr_addr_i, rs_b_addr_i) |
                    addr_match(wb_wr_en_i, wb_wr_addr_i, rs_b_addr_i);
        stall_o   = (rs_a_used_i & match_a_s) | (rs_b_used_i & match_b_s);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Run/halt/single-step sequencer for the 4-stage CPU pipeline with hazard
// stalls and branch flush. Define PIPE_CTRL_PERF_EN to build the perf counters.
module pipeline_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             step_i,
    input  logic [2:0]       rs_a_addr_i,
    input  logic [2:0]       rs_b_addr_i,
    input  logic             rs_a_used_i,
    input  logic             rs_b_used_i,
    input  logic             ex_wr_en_i,
    input  logic [2:0]       ex_wr_addr_i,
    input  logic             wb_wr_en_i,
    input  logic [2:0]       wb_wr_addr_i,
    input  logic             branch_req_i,
    output logic             pc_en_o,
    output logic             fetch_en_o,
    output logic             fetch_bubble_o,
    output logic             dec_bubble_o,
    output logic             branch_en_o,
    output logic [1:0]       state_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

    pipe_state_t        state_r;
    pipe_state_t        state_nxt_s;
    logic [DRAIN_W-1:0] drain_cnt_r;
    logic [DRAIN_W-1:0] drain_nxt_s;
    logic               stall_s;
    logic               branch_en_s;
    logic               mode_pc_en_s;
    logic               mode_fetch_en_s;
    logic               mode_fetch_bubble_s;
    logic               mode_dec_bubble_s;

    hazard_detect u_hazard_detect (
        .rs_a_used_i  (rs_a_used_i),
        .rs_a_addr_i  (rs_a_addr_i),
        .rs_b_used_i  (rs_b_used_i),
        .rs_b_addr_i  (rs_b_addr_i),
        .ex_wr_en_i   (ex_wr_en_i),
        .ex_wr_addr_i (ex_wr_addr_i),
        .wb_wr_en_i   (wb_wr_en_i),
        .wb_wr_addr_i (wb_wr_addr_i),
        .stall_o      (stall_s)
    );

    // Mode FSM next-state, drain counter update and per-mode issue controls.
    always_comb begin
        state_nxt_s         = state_r;
        drain_nxt_s         = drain_cnt_r;
        mode_pc_en_s        = 1'b0;
        mode_fetch_en_s     = 1'b1;
        mode_fetch_bubble_s = 1'b1;
        mode_dec_bubble_s   = 1'b1;
        case (state_r)
            ST_HALT: begin
                if (step_i) begin
                    state_nxt_s = ST_STEP;
                end else if (run_i) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            ST_RUN: begin
                mode_pc_en_s        = 1'b1;
                mode_fetch_bubble_s = 1'b0;
                mode_dec_bubble_s   = 1'b0;
                if (!run_i) begin
                    state_nxt_s = ST_DRAIN;
                    drain_nxt_s = DRAIN_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_STEP: begin
                mode_pc_en_s        = 1'b1;
                mode_fetch_bubble_s = 1'b0;
                mode_dec_bubble_s   = 1'b0;
                if (!stall_s) begin
                    state_nxt_s = ST_DRAIN;
                    drain_nxt_s = DRAIN_LOAD;
                end else begin
                    state_nxt_s = ST_STEP;
                end
            end
            ST_DRAIN: begin
                mode_dec_bubble_s = 1'b0;
                // Leaving on the final decrement keeps DRAIN exactly DRAIN_CYCLES long.
                if (stall_s) begin
                    state_nxt_s = ST_DRAIN;
                end else if (drain_cnt_r <= DRAIN_W'(1)) begin
                    state_nxt_s = ST_HALT;
                    drain_nxt_s = {DRAIN_W{1'b0}};
                end else begin
                    drain_nxt_s = drain_cnt_r - DRAIN_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_HALT;
                drain_nxt_s = {DRAIN_W{1'b0}};
            end
        endcase
    end

    assign branch_en_s = branch_req_i & ~stall_s & (state_r != ST_HALT);

    // Final issue controls: a stall overrides a branch flush, which overrides the mode.
    always_comb begin
        branch_en_o = branch_en_s;
        if (stall_s) begin
            pc_en_o        = 1'b0;
            fetch_en_o     = 1'b0;
            fetch_bubble_o = mode_fetch_bubble_s;
            dec_bubble_o   = 1'b1;
        end else if (branch_en_s) begin
            pc_en_o        = mode_pc_en_s;
            fetch_en_o     = mode_fetch_en_s;
            fetch_bubble_o = 1'b1;
            dec_bubble_o   = mode_dec_bubble_s;
        end else begin
            pc_en_o        = mode_pc_en_s;
            fetch_en_o     = mode_fetch_en_s;
            fetch_bubble_o = mode_fetch_bubble_s;
            dec_bubble_o   = mode_dec_bubble_s;
        end
    end

    // State and drain counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_HALT;
            drain_cnt_r <= {DRAIN_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            drain_cnt_r <= drain_nxt_s;
        end
    end

    assign state_o = state_r;
    assign busy_o  = (state_r != ST_HALT);

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                                 input logic             en);
        if (en && (val != {CNT_W{1'b1}})) begin
            return val + CNT_W'(1);
        end else begin
            return val;
        end
    endfunction

    // Saturating stall and branch-flush event counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_r <= sat_inc(stall_cnt_r, stall_s);
            flush_cnt_r <= sat_inc(flush_cnt_r, branch_en_s);
        end
    end

    assign stall_cnt_o = stall_cnt_r;
    assign flush_cnt_o = flush_cnt_r;
`else
    assign stall_cnt_o = {CNT_W{1'b0}};
    assign flush_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl with a queue scoreboard of
// per-cycle expected control outputs; counter checks follow PIPE_CTRL_PERF_EN.
module tb_pipeline_ctrl;

    localparam int CNT_W = 16;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             run_i = 1'b0;
    logic             step_i = 1'b0;
    logic [2:0]       rs_a_addr_i = 3'd0;
    logic [2:0]       rs_b_addr_i = 3'd0;
    logic             rs_a_used_i = 1'b0;
    logic             rs_b_used_i = 1'b0;
    logic             ex_wr_en_i = 1'b0;
    logic [2:0]       ex_wr_addr_i = 3'd0;
    logic             wb_wr_en_i = 1'b0;
    logic [2:0]       wb_wr_addr_i = 3'd0;
    logic             branch_req_i = 1'b0;
    logic             pc_en_o;
    logic             fetch_en_o;
    logic             fetch_bubble_o;
    logic             dec_bubble_o;
    logic             branch_en_o;
    logic [1:0]       state_o;
    logic             busy_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    typedef struct packed {
        logic       pc;
        logic       fe;
        logic       fb;
        logic       db;
        logic       be;
        logic [1:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   cmp_cnt  = 0;
    int   fail_cnt = 0;

    pipeline_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(3)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .run_i          (run_i),
        .step_i         (step_i),
        .rs_a_addr_i    (rs_a_addr_i),
        .rs_b_addr_i    (rs_b_addr_i),
        .rs_a_used_i    (rs_a_used_i),
        .rs_b_used_i    (rs_b_used_i),
        .ex_wr_en_i     (ex_wr_en_i),
        .ex_wr_addr_i   (ex_wr_addr_i),
        .wb_wr_en_i     (wb_wr_en_i),
        .wb_wr_addr_i   (wb_wr_addr_i),
        .branch_req_i   (branch_req_i),
        .pc_en_o        (pc_en_o),
        .fetch_en_o     (fetch_en_o),
        .fetch_bubble_o (fetch_bubble_o),
        .dec_bubble_o   (dec_bubble_o),
        .branch_en_o    (branch_en_o),
        .state_o        (state_o),
        .busy_o         (busy_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int perf(input int v);
`ifdef PIPE_CTRL_PERF_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic check_val(input string tag, input int obs, input int expv);
        cmp_cnt++;
        assert (obs === expv) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Called at a negedge with inputs already driven: score this cycle, then advance.
    task automatic chk(input string tag, input logic pc, input logic fe, input logic fb,
                       input logic db, input logic be, input logic [1:0] st);
        exp_t e;
        exp_q.push_back('{pc: pc, fe: fe, fb: fb, db: db, be: be, st: st});
        #1;
        e = exp_q.pop_front();
        check_val({tag, ".pc_en"},        int'(pc_en_o),        int'(e.pc));
        check_val({tag, ".fetch_en"},     int'(fetch_en_o),     int'(e.fe));
        check_val({tag, ".fetch_bubble"}, int'(fetch_bubble_o), int'(e.fb));
        check_val({tag, ".dec_bubble"},   int'(dec_bubble_o),   int'(e.db));
        check_val({tag, ".branch_en"},    int'(branch_en_o),    int'(e.be));
        check_val({tag, ".state"},        int'(state_o),        int'(e.st));
        check_val({tag, ".busy"},         int'(busy_o),         int'(e.st != 2'd0));
        @(negedge clk_i);
    endtask

    task automatic clear_hazards();
        rs_a_used_i  = 1'b0;
        rs_b_used_i  = 1'b0;
        ex_wr_en_i   = 1'b0;
        wb_wr_en_i   = 1'b0;
        branch_req_i = 1'b0;
    endtask

    initial begin
        // Reset
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("reset", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
        check_val("reset.stall_cnt", int'(stall_cnt_o), 0);
        check_val("reset.flush_cnt", int'(flush_cnt_o), 0);

        // Run request: still HALT this cycle, RUN with pc_en next cycle
        run_i = 1'b1;
        chk("run_req", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
        chk("run_first", 1'b1, 1'b1, 1'b0, 0, 1'b0, 2'd1);

        // Execute-latch hazard on r2: two stall cycles as the writer moves to writeback
        rs_a_addr_i = 3'd2; rs_a_used_i = 1'b1; ex_wr_en_i = 1'b1; ex_wr_addr_i = 3'd2;
        chk("ex_haz1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
        ex_wr_en_i = 1'b0; wb_wr_en_i = 1'b1; wb_wr_addr_i = 3'd2;
        chk("ex_haz2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
        clear_hazards();
        chk("ex_clear", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        check_val("ex_haz.stall_cnt", int'(stall_cnt_o), perf(2));

        // Writeback-only hazard on r5 via source b: one stall cycle
        rs_b_addr_i = 3'd5; rs_b_used_i = 1'b1; wb_wr_en_i = 1'b1; wb_wr_addr_i = 3'd5;
        chk("wb_haz", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
        clear_hazards();
        chk("wb_clear", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);

        // Same match with the source unused (immediate form): no stall
        rs_a_addr_i = 3'd5; rs_a_used_i = 1'b0; wb_wr_en_i = 1'b1; wb_wr_addr_i = 3'd5;
        chk("wb_unused", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        clear_hazards();
        check_val("wb.stall_cnt", int'(stall_cnt_o), perf(3));

        // Branch without hazard flushes fetch for one cycle
        branch_req_i = 1'b1;
        chk("branch", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1);
        branch_req_i = 1'b0;
        chk("branch_done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        check_val("branch.flush_cnt", int'(flush_cnt_o), perf(1));

        // Branch during a stall is suppressed
        branch_req_i = 1'b1; rs_a_addr_i = 3'd3; rs_a_used_i = 1'b1;
        ex_wr_en_i = 1'b1; ex_wr_addr_i = 3'd3;
        chk("branch_stall", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
        clear_hazards();
        check_val("branch_stall.flush_cnt", int'(flush_cnt_o), perf(1));

        // Drop run: three drain cycles, then HALT
        run_i = 1'b0;
        chk("run_drop", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        chk("drain1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
        chk("drain2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
        chk("drain3", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
        chk("halted", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);

        // Step and run together: STEP wins; one issue cycle, busy for 4 cycles
        step_i = 1'b1; run_i = 1'b1;
        chk("step_req", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
        step_i = 1'b0; run_i = 1'b0;
        chk("step_issue", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
        chk("sdrain1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
        chk("sdrain2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
        chk("sdrain3", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
        chk("step_halt", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);

        // Step with a stall during DRAIN extends busy by one cycle; step ignored in DRAIN
        step_i = 1'b1;
        chk("step2_req", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
        step_i = 1'b0;
        chk("step2_issue", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
        step_i = 1'b1;
        chk("s2drain1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
        step_i = 1'b0;
        rs_b_addr_i = 3'd6; rs_b_used_i = 1'b1; wb_wr_en_i = 1'b1; wb_wr_addr_i = 3'd6;
        chk("s2drain_stall", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3);
        clear_hazards();
        chk("s2drain2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
        chk("s2drain3", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
        chk("step2_halt", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
        check_val("pre_rst.stall_cnt", int'(stall_cnt_o), perf(5));
        check_val("pre_rst.flush_cnt", int'(flush_cnt_o), perf(1));

        // Run, drop run, then reset one cycle later: HALT next edge, counters cleared
        run_i = 1'b1;
        chk("run2_req", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
        run_i = 1'b0;
        chk("run2_drop", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        rst_i = 1'b1;
        chk("rst_in_drain", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
        rst_i = 1'b0;
        chk("rst_halt", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
        check_val("rst.stall_cnt", int'(stall_cnt_o), 0);
        check_val("rst.flush_cnt", int'(flush_cnt_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Sequencer for the 4-stage fetch/decode/execute/writeback CPU pipeline. It owns run/halt/single-step mode and detects read-after-write hazards between decode and the execute/writeback latches. It gates PC advance and fetch-latch load, injects bubbles, and qualifies taken branches before the branch unit sees them. It sits between the front-panel state machine and the fetch/decode stages.

## Interface
- `CNT_W`, default 16: width of the performance counters.
- `DRAIN_CYCLES`, default 3: cycles needed to retire the last fetched instruction.
- `clk_i`  in  1  pipeline clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `run_i`  in  1  level; free-run request.
- `step_i`  in  1  one-cycle pulse; single-step request, honored only in HALT.
- `rs_a_addr_i`, `rs_b_addr_i`  in  3 each  decode-stage source register addresses.
- `rs_a_used_i`, `rs_b_used_i`  in  1 each  source actually read (immediate forms clear `rs_a_used_i`).
- `ex_wr_en_i`, `ex_wr_addr_i`  in  1/3  write enable and address held in the decode latch.
- `wb_wr_en_i`, `wb_wr_addr_i`  in  1/3  write enable and address held in the execute latch.
- `branch_req_i`  in  1  decode-stage branch condition met.
- `pc_en_o`  out  1  PC may advance.
- `fetch_en_o`  out  1  load the fetch latch.
- `fetch_bubble_o`  out  1  load NOP into the fetch latch instead of memory data.
- `dec_bubble_o`  out  1  load the decode latch with `wr_en`=0 and NOP opcode.
- `branch_en_o`  out  1  qualified branch to the branch unit.
- `state_o`  out  2  HALT=0, RUN=1, STEP=2, DRAIN=3.
- `busy_o`  out  1  state != HALT.
- `stall_cnt_o`, `flush_cnt_o`  out  CNT_W each  performance counters.

## Operation
- Hazard: `stall` = (`rs_a_used_i` & match) | (`rs_b_used_i` & match), where match = (`ex_wr_en_i` & addr == `ex_wr_addr_i`) | (`wb_wr_en_i` & addr == `wb_wr_addr_i`). The register file writes at the clock edge, so a writeback-stage match is also a hazard.
- During a stall: `pc_en_o`=0, `fetch_en_o`=0 (fetch latch holds), `dec_bubble_o`=1, `branch_en_o`=0.
- `branch_en_o` = `branch_req_i` & ~`stall` & state != HALT. When it is high, `fetch_bubble_o`=1 to flush the wrong-path fetch. The decode latch is unaffected.
- Priority: `rst_i` > stall > branch > mode.
- HALT: `pc_en_o`=0, `fetch_en_o`=1, `fetch_bubble_o`=1, `dec_bubble_o`=1. `step_i` goes to STEP; otherwise `run_i` goes to RUN. If both are asserted, STEP wins.
- RUN: normal issue. When `run_i`=0, go to DRAIN and load the drain counter with DRAIN_CYCLES.
- STEP: one issue cycle. If it is not stalled, go to DRAIN next cycle; if it is stalled, hold in STEP.
- DRAIN: `pc_en_o`=0, fetch loads NOP, later stages proceed. The counter decrements only on non-stall cycles. At 0, go to HALT. `run_i` and `step_i` are ignored until HALT.
- Counters saturate at all-ones. `stall_cnt_o` increments on each stall cycle; `flush_cnt_o` increments on each `branch_en_o` cycle.

## Timing
- State is registered. Stall, bubble, PC and branch outputs are combinational from the current state and inputs (same cycle).
- Reset values: state HALT, so `pc_en_o`=0, `fetch_bubble_o`=1, `dec_bubble_o`=1, `branch_en_o`=0, `busy_o`=0. Drain counter 0, counters 0.
- `run_i` sampled high at edge N: RUN during cycle N+1, with the first `pc_en_o` in that cycle.
- Step from an empty pipeline: exactly 1 `pc_en_o` cycle, then DRAIN_CYCLES cycles, then HALT. `busy_o` is high for 1+DRAIN_CYCLES cycles.
- A hazard against the execute latch stalls 2 cycles; a hazard against the writeback latch stalls 1 cycle.
- Asserting `rst_i` mid-operation returns to HALT on the next edge. In-flight latches are the datapath's responsibility.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: both counters are implemented as described.
- Not defined: `stall_cnt_o` and `flush_cnt_o` are tied to 0, no counter flops exist, and the ports remain.

## Structure
- Package `cpu_ctrl_pkg`: state encoding (HALT/RUN/STEP/DRAIN), the 13-bit `NOP_INSTR` constant, and the default for `DRAIN_CYCLES`.
- Sub-module `hazard_detect`: the combinational source-versus-destination compare producing `stall`. The FSM, drain counter and counters stay in `pipeline_ctrl`.

## Test plan
- Reset, then `run_i`=1 at edge 2 → `state_o`=1 and `pc_en_o`=1 from cycle 3. Before that, `fetch_bubble_o`=1.
- RUN: decode reads r2 (`rs_a_used_i`=1) while `ex_wr_en_i`=1 with `ex_wr_addr_i`=2 → 2 stall cycles with `pc_en_o`=0 and `dec_bubble_o`=1, `stall_cnt_o`=2.
- Writeback-only match on r5 → 1 stall cycle. With `rs_a_used_i`=0, the same match causes no stall.
- `branch_req_i`=1 without a hazard → `branch_en_o`=1 and `fetch_bubble_o`=1 for one cycle, `flush_cnt_o`=1. The same request during a stall → `branch_en_o`=0.
- In HALT, pulse `step_i` → 1 `pc_en_o` cycle, `busy_o` high for 4 cycles, then HALT. A stall during DRAIN extends `busy_o` by 1.
- `run_i` dropped in RUN with `rst_i` asserted 1 cycle later → HALT next edge, with counters 0.
